cdc_sync_data_freeze: RTL and testbench

CDC_SYNC_DATA_FREEZE -- requirements
Module: cdc_sync_data_freeze

---
 rtl/cdc_sync_data_freeze_pkg.sv | 23 ++
 rtl/cdc_sync_bit_chain.sv | 30 +++
 rtl/cdc_sync_data_freeze.sv | 125 ++++++++++++
 tb/tb_cdc_sync_data_freeze.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/cdc_sync_data_freeze_pkg.sv
// Shared types and helpers for the cdc_sync_data_freeze block.
//   qual_act_e : per-cycle decision of the qualification logic
//   cnt_width  : bit width of a counter that must hold values 0..n-1
package cdc_sync_data_freeze_pkg;

    // What the qualifier does with the candidate on a given cycle.
    typedef enum logic [1:0] {
        ACT_RELOAD = 2'd0,  // new sample differs from candidate: restart
        ACT_COUNT  = 2'd1,  // candidate confirmed again, not yet old enough
        ACT_FREEZE = 2'd2   // candidate held long enough: publish it
    } qual_act_e;

    localparam int unsigned MAX_NUM_BITS      = 64;
    localparam int unsigned MIN_SYNC_STAGES   = 2;
    localparam int unsigned MAX_SYNC_STAGES   = 4;
    localparam int unsigned MAX_STABLE_CYCLES = 255;

    // Width able to represent 0..n-1, never less than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cdc_sync_bit_chain.sv
// Single-bit multi-flop synchroniser for an asynchronous input.
//   clk     : destination clock
//   rst_n   : asynchronous active-low reset, stages load RESET_BIT
//   i_d     : asynchronous input bit
//   o_q     : synchronised output (last stage)
module cdc_sync_bit_chain #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RESET_BIT   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    // Metastability-hardening chain; kept intact and placed close together.
    (* ASYNC_REG = "TRUE" *) (* keep = "true" *)
    logic [SYNC_STAGES-1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= {SYNC_STAGES{RESET_BIT}};
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/cdc_sync_data_freeze.sv
// Multi-bit CDC synchroniser that only publishes a bus value after it has
// been seen unchanged for STABLE_CYCLES consecutive synchronised samples,
// so bit skew between lanes never reaches the output.
//   clk_out  : destination clock
//   resetn   : asynchronous active-low reset
//   bits_in  : asynchronous NUM_BITS bus
//   bits_out : frozen, qualified copy of bits_in
//   stable   : bits_out matches the settled candidate and the live sample
//   update   : one-cycle pulse when bits_out changes value
module cdc_sync_data_freeze
    import cdc_sync_data_freeze_pkg::*;
#(
    parameter int unsigned         NUM_BITS      = 2,
    parameter int unsigned         SYNC_STAGES   = 2,
    parameter int unsigned         STABLE_CYCLES = 4,
    parameter logic [NUM_BITS-1:0] RESET_VALUE   = '0
) (
    input  logic                clk_out,
    input  logic                resetn,
    input  logic [NUM_BITS-1:0] bits_in,
    output logic [NUM_BITS-1:0] bits_out,
    output logic                stable,
    output logic                update
);

    localparam int unsigned     CNT_W   = cnt_width(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    // Parameter range checks at elaboration.
    if (NUM_BITS < 1 || NUM_BITS > MAX_NUM_BITS) begin : g_bad_num_bits
        $error("cdc_sync_data_freeze: NUM_BITS out of range 1..64");
    end
    if (SYNC_STAGES < MIN_SYNC_STAGES || SYNC_STAGES > MAX_SYNC_STAGES) begin : g_bad_sync
        $error("cdc_sync_data_freeze: SYNC_STAGES out of range 2..4");
    end
    if (STABLE_CYCLES < 1 || STABLE_CYCLES > MAX_STABLE_CYCLES) begin : g_bad_stable
        $error("cdc_sync_data_freeze: STABLE_CYCLES out of range 1..255");
    end

    logic [NUM_BITS-1:0] w_sample;
    logic [NUM_BITS-1:0] r_cand;
    logic [CNT_W-1:0]    r_cnt;
    logic [NUM_BITS-1:0] r_bits_out;
    logic                r_stable;
    logic                r_update;

    qual_act_e           w_act;
    logic [NUM_BITS-1:0] w_cand_nxt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic [NUM_BITS-1:0] w_out_nxt;
    logic                w_update_nxt;
    logic                w_stable_nxt;

    // One independent synchroniser per bus bit.
    for (genvar g = 0; g < NUM_BITS; g++) begin : g_sync
        cdc_sync_bit_chain #(
            .SYNC_STAGES (SYNC_STAGES),
            .RESET_BIT   (RESET_VALUE[g])
        ) u_chain (
            .clk   (clk_out),
            .rst_n (resetn),
            .i_d   (bits_in[g]),
            .o_q   (w_sample[g])
        );
    end

    // Qualification decision and next-state values.
    always_comb begin
        w_act        = ACT_RELOAD;
        w_cand_nxt   = r_cand;
        w_cnt_nxt    = r_cnt;
        w_out_nxt    = r_bits_out;
        w_update_nxt = 1'b0;
        w_stable_nxt = (r_bits_out == r_cand) && (w_sample == r_cand);

        if (w_sample != r_cand) begin
            w_act = ACT_RELOAD;
        end else if (r_cnt != CNT_MAX) begin
            w_act = ACT_COUNT;
        end else begin
            w_act = ACT_FREEZE;
        end

        case (w_act)
            ACT_RELOAD: begin
                w_cand_nxt = w_sample;
                w_cnt_nxt  = '0;
            end
            ACT_COUNT: begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
            end
            ACT_FREEZE: begin
                // Counter saturates; republishing an equal value is silent.
                w_out_nxt    = r_cand;
                w_update_nxt = (r_cand != r_bits_out);
            end
            default: begin
                w_cand_nxt = w_sample;
                w_cnt_nxt  = '0;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk_out or negedge resetn) begin
        if (!resetn) begin
            r_cand     <= RESET_VALUE;
            r_cnt      <= '0;
            r_bits_out <= RESET_VALUE;
            r_stable   <= 1'b1;
            r_update   <= 1'b0;
        end else begin
            r_cand     <= w_cand_nxt;
            r_cnt      <= w_cnt_nxt;
            r_bits_out <= w_out_nxt;
            r_stable   <= w_stable_nxt;
            r_update   <= w_update_nxt;
        end
    end

    assign bits_out = r_bits_out;
    assign stable   = r_stable;
    assign update   = r_update;

endmodule

// File: tb/tb_cdc_sync_data_freeze.sv
`timescale 1ns/1ps
module tb_cdc_sync_data_freeze;

    logic       clk_out = 1'b0;
    logic       resetn  = 1'b1;
    logic [1:0] bits_in = 2'd0;
    logic [1:0] bits_out;
    logic       stable;
    logic       update;

    int n_pass  = 0;
    int n_total = 0;

    cdc_sync_data_freeze dut (
        .clk_out  (clk_out),
        .resetn   (resetn),
        .bits_in  (bits_in),
        .bits_out (bits_out),
        .stable   (stable),
        .update   (update)
    );

    // 2 ns destination clock.
    always #1 clk_out = ~clk_out;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_out);
    endtask

    initial begin
        logic [1:0] vals [4];
        logic [1:0] prev;
        int         pulses;
        bit         seen [4];
        logic [1:0] drv_prev;
        int         run;

        // ---- reset held, then released with bits_in = 0 ----
        resetn  = 1'b0;
        bits_in = 2'd0;
        tick(3);
        chk("rst_bits_out", 64'(bits_out), 64'd0);
        chk("rst_stable", 64'(stable), 64'd1);
        chk("rst_update", 64'(update), 64'd0);
        resetn = 1'b1;
        pulses = 0;
        for (int k = 1; k <= 12; k++) begin
            tick(1);
            if (update === 1'b1) pulses++;
        end
        chk("idle_pulses", 64'(pulses), 64'd0);
        chk("idle_bits_out", 64'(bits_out), 64'd0);
        chk("idle_stable", 64'(stable), 64'd1);

        // ---- stepped values, each held 12 cycles, latency 7 edges ----
        vals[0] = 2'd1; vals[1] = 2'd2; vals[2] = 2'd3; vals[3] = 2'd0;
        prev = 2'd0;
        for (int s = 0; s < 4; s++) begin
            bits_in = vals[s];
            pulses  = 0;
            for (int k = 1; k <= 12; k++) begin
                tick(1);
                if (update === 1'b1) pulses++;
                if (k == 6) chk($sformatf("step%0d_edge6", s), 64'(bits_out), 64'(prev));
                if (k == 7) begin
                    chk($sformatf("step%0d_edge7", s), 64'(bits_out), 64'(vals[s]));
                    chk($sformatf("step%0d_upd7", s), 64'(update), 64'd1);
                end
                if (k == 8) chk($sformatf("step%0d_upd8", s), 64'(update), 64'd0);
            end
            chk($sformatf("step%0d_pulses", s), 64'(pulses), 64'd1);
            chk($sformatf("step%0d_stable", s), 64'(stable), 64'd1);
            prev = vals[s];
        end

        // ---- 0 -> 3 with one cycle of skew through 1 ----
        bits_in = 2'd1;
        tick(1);
        bits_in = 2'd3;
        for (int k = 1; k <= 16; k++) begin
            tick(1);
            chk($sformatf("skew_k%0d", k), 64'(bits_out), (k >= 7) ? 64'd3 : 64'd0);
            if (k == 7) chk("skew_upd", 64'(update), 64'd1);
        end

        // ---- fast toggle 1/2 every 2 cycles: output frozen at 3 ----
        for (int k = 1; k <= 40; k++) begin
            if (((k - 1) % 4) == 0) bits_in = 2'd1;
            if (((k - 1) % 4) == 2) bits_in = 2'd2;
            tick(1);
            if (k >= 4) begin
                chk($sformatf("tog_out_k%0d", k), 64'(bits_out), 64'd3);
                chk($sformatf("tog_stable_k%0d", k), 64'(stable), 64'd0);
            end
        end

        // ---- reset pulse while qualifying 2 ----
        bits_in = 2'd0;
        tick(12);
        bits_in = 2'd2;
        tick(3);
        resetn = 1'b0;
        #0.2;
        chk("midrst_bits_out", 64'(bits_out), 64'd0);
        chk("midrst_stable", 64'(stable), 64'd1);
        chk("midrst_update", 64'(update), 64'd0);
        tick(3);
        resetn = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick(1);
            if (k == 6) chk("midrst_edge6", 64'(bits_out), 64'd0);
            if (k == 7) begin
                chk("midrst_edge7", 64'(bits_out), 64'd2);
                chk("midrst_upd7", 64'(update), 64'd1);
            end
        end

        // ---- asynchronous 6 ns source against 2 ns clock ----
        for (int i = 0; i < 4; i++) seen[i] = 1'b0;
        seen[2]  = 1'b1;
        drv_prev = 2'd2;
        run      = 100;
        fork
            begin
                #0.37;
                for (int i = 0; i < 40; i++) begin
                    logic [1:0] v;
                    int         h;
                    v = 2'($urandom_range(0, 3));
                    h = int'($urandom_range(1, 4));
                    run = (v == drv_prev) ? run + h : h;
                    // Only values held >= 12 ns (6 samples) may ever be frozen.
                    if (run >= 2) seen[v] = 1'b1;
                    bits_in  = v;
                    drv_prev = v;
                    #(6.0 * h);
                end
            end
            begin
                for (int k = 0; k < 300; k++) begin
                    tick(1);
                    chk("async_known", 64'($isunknown({bits_out, stable, update})), 64'd0);
                    chk("async_held", 64'(seen[bits_out]), 64'd1);
                end
            end
        join
        @(negedge clk_out);
        bits_in = 2'd1;
        tick(12);
        chk("async_final", 64'(bits_out), 64'd1);
        chk("async_final_stable", 64'(stable), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
